mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arb_sel.sv | 48 ++++
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the IFU/LSU memory arbiter: access widths, FSM states, owner.
package mem_arbiter_pkg;

   localparam int unsigned AddrWidth  = 32;
   localparam int unsigned WdtTypeCnt = 4;
   localparam int unsigned WdtWidth   = $clog2(WdtTypeCnt);

   typedef enum logic [WdtWidth-1:0] {
      Wdt8  = 2'd0,
      Wdt16 = 2'd1,
      Wdt32 = 2'd2,
      Wdt64 = 2'd3
   } wdt_e;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StResp
   } arb_state_e;

   typedef enum logic {
      OwnIfu,
      OwnLsu
   } owner_e;

endpackage

// File: rtl/mem_arb_sel.sv
// Grant selection between IFU and LSU with an IFU starvation counter.
module mem_arb_sel #(
   parameter int unsigned STARVE_LIM = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic idle,
   input  logic ifu_valid,
   input  logic lsu_valid,
   output logic sel_ifu,
   output logic sel_lsu
);

   // +2 keeps the counter at least one bit wide when STARVE_LIM is 0.
   localparam int unsigned CntW = $clog2(STARVE_LIM + 2);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            starved;

   // LSU has priority unless the waiting IFU has hit the starvation limit.
   always_comb begin
      starved = (cnt_q == CntW'(STARVE_LIM)) & ifu_valid;
      sel_lsu = lsu_valid & ~starved;
      sel_ifu = ifu_valid & ~sel_lsu;
   end

   // Counter only moves in IDLE, where a selection is always a grant.
   always_comb begin
      cnt_d = cnt_q;
      if (idle) begin
         if (!ifu_valid || sel_ifu) begin
            cnt_d = '0;
         end else if (sel_lsu && (cnt_q != CntW'(STARVE_LIM))) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding memory arbiter between instruction fetch and load/store.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIM = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ifu_req_valid,
   output logic                 ifu_req_ready,
   input  logic [63:0]          ifu_addr,
   output logic                 ifu_rsp_valid,
   input  logic                 ifu_rsp_ready,
   output logic [31:0]          ifu_rdata,
   input  logic                 lsu_req_valid,
   output logic                 lsu_req_ready,
   input  logic [63:0]          lsu_addr,
   input  logic                 lsu_we,
   input  logic [63:0]          lsu_wdata,
   input  logic [WdtWidth-1:0]  lsu_wdt,
   output logic                 lsu_rsp_valid,
   input  logic                 lsu_rsp_ready,
   output logic [63:0]          lsu_rdata,
   output logic [63:0]          mem_raddr,
   output logic [AddrWidth-1:0] mem_waddr,
   output logic [63:0]          mem_wdata,
   output logic                 mem_wen,
   output logic                 mem_ren,
   output logic [WdtWidth-1:0]  wdt_op,
   input  logic [63:0]          mem_rdata
);

   arb_state_e  state_q;
   owner_e      owner_q;
   logic        we_q;
   logic [63:0] addr_q;
   logic [63:0] wdata_q;
   wdt_e        wdt_q;
   logic        mem_ren_q, mem_wen_q;
   logic        ifu_rsp_valid_q, lsu_rsp_valid_q;
   logic [31:0] ifu_rdata_q;
   logic [63:0] lsu_rdata_q;

   logic idle, sel_ifu, sel_lsu;
   logic ifu_hs, lsu_hs, rsp_hs;

   assign idle = (state_q == StIdle);

   mem_arb_sel #(
      .STARVE_LIM(STARVE_LIM)
   ) u_sel (
      .clk      (clk),
      .rst      (rst),
      .idle     (idle),
      .ifu_valid(ifu_req_valid),
      .lsu_valid(lsu_req_valid),
      .sel_ifu  (sel_ifu),
      .sel_lsu  (sel_lsu)
   );

   // Ready and strobes are masked by rst so nothing handshakes or fires in a reset cycle.
   always_comb begin
      ifu_req_ready = idle & sel_ifu & ~rst;
      lsu_req_ready = idle & sel_lsu & ~rst;
      mem_ren       = mem_ren_q & ~rst;
      mem_wen       = mem_wen_q & ~rst;
      ifu_hs        = ifu_req_valid & ifu_req_ready;
      lsu_hs        = lsu_req_valid & lsu_req_ready;
      rsp_hs        = (ifu_rsp_valid_q & ifu_rsp_ready) | (lsu_rsp_valid_q & lsu_rsp_ready);
   end

   assign mem_raddr     = addr_q;
   assign mem_waddr     = addr_q[AddrWidth-1:0];
   assign mem_wdata     = wdata_q;
   assign wdt_op        = wdt_q;
   assign ifu_rsp_valid = ifu_rsp_valid_q;
   assign lsu_rsp_valid = lsu_rsp_valid_q;
   assign ifu_rdata     = ifu_rdata_q;
   assign lsu_rdata     = lsu_rdata_q;

   // Transaction FSM with registered strobes, response flags and data.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= StIdle;
         owner_q         <= OwnIfu;
         we_q            <= 1'b0;
         addr_q          <= '0;
         wdata_q         <= '0;
         wdt_q           <= Wdt8;
         mem_ren_q       <= 1'b0;
         mem_wen_q       <= 1'b0;
         ifu_rsp_valid_q <= 1'b0;
         lsu_rsp_valid_q <= 1'b0;
         ifu_rdata_q     <= '0;
         lsu_rdata_q     <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (lsu_hs) begin
                  owner_q   <= OwnLsu;
                  we_q      <= lsu_we;
                  addr_q    <= lsu_addr;
                  wdata_q   <= lsu_wdata;
                  wdt_q     <= wdt_e'(lsu_wdt);
                  mem_ren_q <= ~lsu_we;
                  mem_wen_q <= lsu_we;
                  state_q   <= StIssue;
               end else if (ifu_hs) begin
                  owner_q   <= OwnIfu;
                  we_q      <= 1'b0;
                  addr_q    <= ifu_addr;
                  wdata_q   <= '0;
                  wdt_q     <= Wdt32;
                  mem_ren_q <= 1'b1;
                  mem_wen_q <= 1'b0;
                  state_q   <= StIssue;
               end
            end
            StIssue: begin
               mem_ren_q <= 1'b0;
               mem_wen_q <= 1'b0;
               state_q   <= StWait;
            end
            StWait: begin
               if (owner_q == OwnIfu) begin
                  ifu_rdata_q     <= mem_rdata[31:0];
                  ifu_rsp_valid_q <= 1'b1;
               end else begin
                  lsu_rdata_q     <= we_q ? 64'd0 : mem_rdata;
                  lsu_rsp_valid_q <= 1'b1;
               end
               state_q <= StResp;
            end
            StResp: begin
               if (rsp_hs) begin
                  ifu_rsp_valid_q <= 1'b0;
                  lsu_rsp_valid_q <= 1'b0;
                  state_q         <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level model checked every cycle,
// plus literal checks on grant order, latency and data.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int LIM = 2;
   localparam byte OwnI = 8'h49;
   localparam byte OwnL = 8'h4C;

   typedef struct {
      logic [63:0] addr;
      logic        we;
      logic [63:0] wdata;
      logic [1:0]  wdt;
   } lreq_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
   logic [63:0] ifu_addr;
   logic [31:0] ifu_rdata;
   logic        lsu_req_valid, lsu_req_ready, lsu_we, lsu_rsp_valid, lsu_rsp_ready;
   logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic [1:0]  lsu_wdt, wdt_op;
   logic [63:0] mem_raddr, mem_wdata, mem_rdata;
   logic [31:0] mem_waddr;
   logic        mem_wen, mem_ren;

   mem_arbiter #(
      .STARVE_LIM(LIM)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ifu_req_valid(ifu_req_valid),
      .ifu_req_ready(ifu_req_ready),
      .ifu_addr     (ifu_addr),
      .ifu_rsp_valid(ifu_rsp_valid),
      .ifu_rsp_ready(ifu_rsp_ready),
      .ifu_rdata    (ifu_rdata),
      .lsu_req_valid(lsu_req_valid),
      .lsu_req_ready(lsu_req_ready),
      .lsu_addr     (lsu_addr),
      .lsu_we       (lsu_we),
      .lsu_wdata    (lsu_wdata),
      .lsu_wdt      (lsu_wdt),
      .lsu_rsp_valid(lsu_rsp_valid),
      .lsu_rsp_ready(lsu_rsp_ready),
      .lsu_rdata    (lsu_rdata),
      .mem_raddr    (mem_raddr),
      .mem_waddr    (mem_waddr),
      .mem_wdata    (mem_wdata),
      .mem_wen      (mem_wen),
      .mem_ren      (mem_ren),
      .wdt_op       (wdt_op),
      .mem_rdata    (mem_rdata)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%h, want 0x%h", name, got, want);
      end
   endtask

   // Memory contents as a pure function of the address.
   function automatic logic [63:0] memf(input logic [63:0] a);
      if (a == 64'h8000_0000) return 64'h0000_0000_0000_0413;
      if (a == 64'h8000_0008) return 64'h1122_3344_5566_7788;
      return {a[31:0] ^ 32'h5A5A_5A5A, ~a[31:0]};
   endfunction

   // Memory: read data appears the cycle after the read strobe.
   always @(posedge clk) begin
      mem_rdata <= mem_ren ? memf(mem_raddr) : 64'hDEAD_0000_DEAD_0000;
   end

   // Requester queues and drivers: hold valid until handshake, then load the next one.
   logic [63:0] ifu_q[$];
   lreq_t       lsu_q[$];

   initial begin
      bit hs;
      hs = 1'b0;
      ifu_req_valid = 1'b0;
      ifu_addr = '0;
      forever begin
         @(negedge clk);
         if (hs) begin
            ifu_req_valid = 1'b0;
            hs = 1'b0;
         end
         if (!ifu_req_valid && ifu_q.size() > 0) begin
            ifu_addr = ifu_q.pop_front();
            ifu_req_valid = 1'b1;
         end
         #3;
         if (ifu_req_valid && ifu_req_ready) hs = 1'b1;
      end
   end

   initial begin
      bit    hs;
      lreq_t r;
      hs = 1'b0;
      lsu_req_valid = 1'b0;
      lsu_addr = '0;
      lsu_we = 1'b0;
      lsu_wdata = '0;
      lsu_wdt = '0;
      forever begin
         @(negedge clk);
         if (hs) begin
            lsu_req_valid = 1'b0;
            hs = 1'b0;
         end
         if (!lsu_req_valid && lsu_q.size() > 0) begin
            r = lsu_q.pop_front();
            lsu_addr = r.addr;
            lsu_we = r.we;
            lsu_wdata = r.wdata;
            lsu_wdt = r.wdt;
            lsu_req_valid = 1'b1;
         end
         #3;
         if (lsu_req_valid && lsu_req_ready) hs = 1'b1;
      end
   end

   // Transaction model: one request at a time, strobe one cycle after grant,
   // response from three cycles after grant until the owner takes it.
   bit          m_started = 1'b0;
   bit          m_busy = 1'b0;
   int          m_k = 0;
   byte         m_own = OwnI;
   logic        m_we = 1'b0;
   logic [63:0] m_addr = '0, m_wdata = '0, m_ifu_rd = '0, m_lsu_rd = '0;
   logic [1:0]  m_wdt = '0;
   int          m_starve = 0;
   int          cyc = 0;

   // DUT event logs for the literal checks.
   byte         g_own[$];
   int          g_cyc[$];
   int          s_cyc[$];
   logic        s_we[$];
   logic [63:0] s_addr[$];
   byte         r_own[$];
   int          r_cyc[$];
   logic [63:0] r_dat[$];
   logic        p_iv = 1'b0, p_lv = 1'b0;

   function automatic byte m_win();
      if (m_busy) return 8'h00;
      if (lsu_req_valid && !(m_starve == LIM && ifu_req_valid)) return OwnL;
      if (ifu_req_valid) return OwnI;
      return 8'h00;
   endfunction

   initial begin
      byte         w;
      logic [63:0] t;
      logic        st, rv;
      forever begin
         @(posedge clk);
         cyc++;
         w = m_win();
         if (rst) begin
            m_started = 1'b1;
            m_busy = 1'b0;
            m_k = 0;
            m_starve = 0;
            m_we = 1'b0;
            m_addr = '0;
            m_wdata = '0;
            m_wdt = '0;
            m_ifu_rd = '0;
            m_lsu_rd = '0;
         end else if (!m_busy) begin
            if (w == OwnL) begin
               m_busy = 1'b1; m_k = 1; m_own = OwnL;
               m_we = lsu_we; m_addr = lsu_addr; m_wdata = lsu_wdata; m_wdt = lsu_wdt;
               m_starve = ifu_req_valid ? ((m_starve < LIM) ? m_starve + 1 : m_starve) : 0;
            end else if (w == OwnI) begin
               m_busy = 1'b1; m_k = 1; m_own = OwnI;
               m_we = 1'b0; m_addr = ifu_addr; m_wdata = '0; m_wdt = 2'd2;
               m_starve = 0;
            end else if (!ifu_req_valid) begin
               m_starve = 0;
            end
         end else if (m_k == 1) begin
            m_k = 2;
         end else if (m_k == 2) begin
            m_k = 3;
            t = memf(m_addr);
            if (m_own == OwnI) m_ifu_rd = {32'h0, t[31:0]};
            else m_lsu_rd = m_we ? 64'd0 : t;
         end else if ((m_own == OwnI && ifu_rsp_ready) || (m_own == OwnL && lsu_rsp_ready)) begin
            m_busy = 1'b0;
         end

         @(negedge clk);
         #2;
         if (m_started) begin
            w  = m_win();
            st = m_busy && m_k == 1 && !rst;
            rv = m_busy && m_k >= 3;
            chk("ifu_req_ready", ifu_req_ready, !rst && w == OwnI);
            chk("lsu_req_ready", lsu_req_ready, !rst && w == OwnL);
            chk("mem_ren", mem_ren, st && !m_we);
            chk("mem_wen", mem_wen, st && m_we);
            chk("ifu_rsp_valid", ifu_rsp_valid, rv && m_own == OwnI);
            chk("lsu_rsp_valid", lsu_rsp_valid, rv && m_own == OwnL);
            chk("mem_raddr", mem_raddr, m_addr);
            chk("mem_waddr", {32'h0, mem_waddr}, {32'h0, m_addr[31:0]});
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("wdt_op", {62'h0, wdt_op}, {62'h0, m_wdt});
            chk("ifu_rdata", {32'h0, ifu_rdata}, m_ifu_rd);
            chk("lsu_rdata", lsu_rdata, m_lsu_rd);

            if (ifu_req_valid && ifu_req_ready) begin g_own.push_back(OwnI); g_cyc.push_back(cyc); end
            if (lsu_req_valid && lsu_req_ready) begin g_own.push_back(OwnL); g_cyc.push_back(cyc); end
            if (mem_ren || mem_wen) begin
               s_cyc.push_back(cyc);
               s_we.push_back(mem_wen);
               s_addr.push_back(mem_wen ? {32'h0, mem_waddr} : mem_raddr);
            end
            if (ifu_rsp_valid && !p_iv) begin
               r_own.push_back(OwnI); r_cyc.push_back(cyc); r_dat.push_back({32'h0, ifu_rdata});
            end
            if (lsu_rsp_valid && !p_lv) begin
               r_own.push_back(OwnL); r_cyc.push_back(cyc); r_dat.push_back(lsu_rdata);
            end
            p_iv = ifu_rsp_valid;
            p_lv = lsu_rsp_valid;
         end
      end
   end

   task automatic clear_logs();
      g_own.delete(); g_cyc.delete(); s_cyc.delete(); s_we.delete(); s_addr.delete();
      r_own.delete(); r_cyc.delete(); r_dat.delete();
   endtask

   task automatic wait_rsp(input int n, input int budget, input string name);
      int i = 0;
      while (r_own.size() < n && i < budget) begin
         @(posedge clk);
         i++;
      end
      chk(name, r_own.size(), n);
   endtask

   task automatic push_lsu(input logic [63:0] a, input logic we, input logic [63:0] d,
                           input logic [1:0] wdt);
      lreq_t r;
      r.addr = a; r.we = we; r.wdata = d; r.wdt = wdt;
      lsu_q.push_back(r);
   endtask

   initial begin
      string exp_ord;
      int    drop_cyc;
      int    i;
      rst = 1'b1;
      ifu_rsp_ready = 1'b1;
      lsu_rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2;
      chk("rst_raddr", mem_raddr, 64'h0);
      chk("rst_ifu_rsp_valid", ifu_rsp_valid, 1'b0);
      chk("rst_lsu_rdata", lsu_rdata, 64'h0);
      chk("rst_wdt_op", {62'h0, wdt_op}, 64'h0);
      rst = 1'b0;

      // Single fetch: latency and data.
      clear_logs();
      ifu_q.push_back(64'h8000_0000);
      wait_rsp(1, 20, "t1_rsp_count");
      chk("t1_grant_owner", g_own[0], OwnI);
      chk("t1_strobe_cycle", s_cyc[0], g_cyc[0] + 1);
      chk("t1_strobe_is_read", s_we[0], 1'b0);
      chk("t1_rsp_cycle", r_cyc[0], g_cyc[0] + 3);
      chk("t1_ifu_rdata", r_dat[0], 64'h0000_0413);

      // Simultaneous requests: LSU first, then IFU.
      repeat (2) @(posedge clk);
      clear_logs();
      push_lsu(64'h8000_0008, 1'b0, 64'h0, 2'd3);
      ifu_q.push_back(64'h8000_0004);
      wait_rsp(2, 30, "t2_rsp_count");
      chk("t2_grant0", g_own[0], OwnL);
      chk("t2_grant1", g_own[1], OwnI);
      chk("t2_rsp0_owner", r_own[0], OwnL);
      chk("t2_rsp1_owner", r_own[1], OwnI);
      chk("t2_lsu_rdata", r_dat[0], 64'h1122_3344_5566_7788);
      chk("t2_ifu_rdata", r_dat[1], 64'h7FFF_FFFB);
      chk("t2_grant_gap", g_cyc[1], g_cyc[0] + 4);

      // Starvation limit: LSU, LSU, IFU, repeating.
      repeat (2) @(posedge clk);
      clear_logs();
      for (int k = 0; k < 6; k++) push_lsu(64'h8000_0100 + 64'(8 * k), 1'b0, 64'h0, 2'd3);
      ifu_q.push_back(64'h8000_0200);
      ifu_q.push_back(64'h8000_0204);
      wait_rsp(8, 80, "t3_rsp_count");
      exp_ord = "LLILLI";
      for (int k = 0; k < 6; k++) chk($sformatf("t3_grant%0d", k), g_own[k], exp_ord[k]);

      // Store: one write strobe, zero response data.
      repeat (2) @(posedge clk);
      clear_logs();
      push_lsu(64'h8000_0010, 1'b1, 64'hDEAD_BEEF, 2'd2);
      wait_rsp(1, 20, "t4_rsp_count");
      chk("t4_strobe_count", s_cyc.size(), 1);
      chk("t4_strobe_is_write", s_we[0], 1'b1);
      chk("t4_waddr", s_addr[0], 64'h8000_0010);
      chk("t4_rsp_owner", r_own[0], OwnL);
      chk("t4_lsu_rdata", r_dat[0], 64'h0);

      // Response back-pressure: held data, no new grant or strobe.
      repeat (2) @(posedge clk);
      clear_logs();
      lsu_rsp_ready = 1'b0;
      push_lsu(64'h8000_0020, 1'b0, 64'h0, 2'd3);
      wait_rsp(1, 20, "t5_rsp_count");
      ifu_q.push_back(64'h8000_0040);
      repeat (5) @(posedge clk);
      @(negedge clk);
      #2;
      chk("t5_lsu_rsp_valid_held", lsu_rsp_valid, 1'b1);
      chk("t5_lsu_rdata_held", lsu_rdata, 64'hDA5A_5A7A_7FFF_FFDF);
      chk("t5_ifu_req_ready", ifu_req_ready, 1'b0);
      chk("t5_grant_count", g_own.size(), 1);
      chk("t5_strobe_count", s_cyc.size(), 1);
      lsu_rsp_ready = 1'b1;
      wait_rsp(2, 20, "t5_rsp_count_after");
      chk("t5_grant1", g_own[1], OwnI);

      // Reset during the issue cycle of a store.
      repeat (2) @(posedge clk);
      clear_logs();
      push_lsu(64'h8000_0030, 1'b1, 64'h55, 2'd3);
      i = 0;
      while (g_own.size() == 0 && i < 10) begin
         @(posedge clk);
         i++;
      end
      chk("t6_store_granted", g_own.size(), 1);
      #1;
      rst = 1'b1;
      ifu_q.push_back(64'h8000_0000);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      drop_cyc = cyc;
      #2;
      chk("t6_mem_wen", mem_wen, 1'b0);
      chk("t6_mem_waddr", {32'h0, mem_waddr}, 64'h0);
      chk("t6_mem_wdata", mem_wdata, 64'h0);
      chk("t6_wdt_op", {62'h0, wdt_op}, 64'h0);
      wait_rsp(1, 20, "t6_rsp_count");
      chk("t6_first_grant_cycle", g_cyc[1], drop_cyc);
      chk("t6_strobe_count", s_cyc.size(), 1);
      chk("t6_strobe_is_read", s_we[0], 1'b0);
      chk("t6_rsp_owner", r_own[0], OwnI);

      repeat (4) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

endmodule
